// File: rtl/nonce_tx_arbiter.sv
// Round-robin scheduler sharing one serial nonce transmitter between NUM_MINERS hashing cores.
// Optional NONCE_TX_STALE_FLUSH_EN: new_work discards every pending nonce not yet granted.
module nonce_tx_arbiter #(
    parameter int unsigned NUM_MINERS  = 4,
    parameter int unsigned NONCE_WIDTH = 32
) (
    input  logic                              hash_clk,
    input  logic                              reset,
    input  logic [NUM_MINERS-1:0]             found,
    input  logic [NUM_MINERS*NONCE_WIDTH-1:0] nonces,
    input  logic                              new_work,
    input  logic                              tx_busy,
    output logic                              tx_start,
    output logic [NONCE_WIDTH-1:0]            tx_data,
    output logic [7:0]                        drop_count
);

    localparam int unsigned PTR_W  = (NUM_MINERS > 1) ? $clog2(NUM_MINERS) : 1;
    localparam int unsigned INC_W  = $clog2(NUM_MINERS + 1);
    localparam int unsigned DROP_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                   state, state_nxt;
    logic [PTR_W-1:0]         rr_ptr;
    logic [NUM_MINERS-1:0]    pending, pending_nxt, eligible_c;
    logic [NONCE_WIDTH-1:0]   slot [NUM_MINERS];
    logic                     flush_c;
    logic                     grant_valid_c, grant_fire_c;
    logic [PTR_W-1:0]         grant_idx_c;
    int unsigned              cand_c;
    logic [INC_W-1:0]         drop_inc_c;
    logic [DROP_W:0]          drop_sum_c;
    logic [DROP_W-1:0]        drop_nxt_c;

`ifdef NONCE_TX_STALE_FLUSH_EN
    assign flush_c = new_work;
`else
    logic unused_new_work;
    assign unused_new_work = new_work;
    assign flush_c         = 1'b0;
`endif

    // A flush in the grant cycle suppresses the stale grant as well.
    assign eligible_c   = pending & ~{NUM_MINERS{flush_c}};
    assign grant_fire_c = (state == IDLE) && grant_valid_c;

    // First eligible slot at or after rr_ptr; descending scan so the nearest one wins.
    always_comb begin
        grant_valid_c = 1'b0;
        grant_idx_c   = '0;
        cand_c        = 0;
        for (int k = NUM_MINERS - 1; k >= 0; k--) begin
            cand_c = 32'(rr_ptr) + 32'(k);
            if (cand_c >= NUM_MINERS) begin
                cand_c = cand_c - NUM_MINERS;
            end
            if (eligible_c[PTR_W'(cand_c)]) begin
                grant_valid_c = 1'b1;
                grant_idx_c   = PTR_W'(cand_c);
            end
        end
    end

    // Capture beats grant and flush; overwrites lost to a flush are not counted as drops.
    always_comb begin
        pending_nxt = pending;
        drop_inc_c  = '0;
        for (int i = 0; i < NUM_MINERS; i++) begin
            if (found[i]) begin
                pending_nxt[i] = 1'b1;
                if (pending[i] && !flush_c &&
                    !(grant_fire_c && (grant_idx_c == PTR_W'(i)))) begin
                    drop_inc_c = drop_inc_c + INC_W'(1);
                end
            end else if ((grant_fire_c && (grant_idx_c == PTR_W'(i))) || flush_c) begin
                pending_nxt[i] = 1'b0;
            end
        end
        drop_sum_c = {1'b0, drop_count} + (DROP_W + 1)'(drop_inc_c);
        drop_nxt_c = drop_sum_c[DROP_W] ? {DROP_W{1'b1}} : drop_sum_c[DROP_W-1:0];
    end

    // Transfer handshake sequencing.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (grant_fire_c) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy) state_nxt = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hash_clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            pending    <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            drop_count <= '0;
            for (int i = 0; i < NUM_MINERS; i++) begin
                slot[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            drop_count <= drop_nxt_c;
            tx_start   <= grant_fire_c;
            for (int i = 0; i < NUM_MINERS; i++) begin
                if (found[i]) begin
                    slot[i] <= nonces[i*NONCE_WIDTH +: NONCE_WIDTH];
                end
            end
            if (grant_fire_c) begin
                tx_data <= slot[grant_idx_c];
                rr_ptr  <= (32'(grant_idx_c) == NUM_MINERS - 1) ? '0 : grant_idx_c + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nonce_tx_arbiter.sv
// Scoreboard bench for nonce_tx_arbiter: directed strobes, transmitter model, queue-based monitor.
module tb_nonce_tx_arbiter;

    localparam int unsigned NM = 4;

    logic              hash_clk = 1'b0;
    logic              reset    = 1'b0;
    logic [NM-1:0]     found    = '0;
    logic [NM*32-1:0]  nonces   = '0;
    logic              new_work = 1'b0;
    logic              tx_busy  = 1'b0;
    logic              tx_start;
    logic [31:0]       tx_data;
    logic [7:0]        drop_count;

    nonce_tx_arbiter #(.NUM_MINERS(NM), .NONCE_WIDTH(32)) dut (
        .hash_clk   (hash_clk),
        .reset      (reset),
        .found      (found),
        .nonces     (nonces),
        .new_work   (new_work),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .drop_count (drop_count)
    );

    always #5 hash_clk = ~hash_clk;

    int cyc = 0;
    always @(posedge hash_clk) cyc++;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Transmitter model: busy rises busy_delay cycles after tx_start, holds busy_len cycles.
    int busy_delay = 1;
    int busy_len   = 40;
    int tx_phase   = 0;
    int tx_cnt     = 0;
    always @(posedge hash_clk) begin
        #2;
        if (!reset) begin
            tx_busy  = 1'b0;
            tx_phase = 0;
        end else begin
            case (tx_phase)
                0: if (tx_start) begin tx_cnt = busy_delay; tx_phase = 1; end
                1: begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin tx_busy = 1'b1; tx_cnt = busy_len; tx_phase = 2; end
                end
                default: begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin tx_busy = 1'b0; tx_phase = 0; end
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every tx_start, checks hold and spacing.
    int          starts         = 0;
    int          last_start_cyc = -1;
    int          fall_cyc       = -1;
    logic        prev_busy      = 1'b0;
    logic [31:0] cur_word       = '0;
    always @(negedge hash_clk) begin
        if (!reset) begin
            prev_busy      = 1'b0;
            last_start_cyc = -1;
            fall_cyc       = -1;
        end else begin
            if (prev_busy && !tx_busy) fall_cyc = cyc;
            if (tx_start) begin
                starts++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got %h expected no start (cycle %0d)", tx_data, cyc);
                end else begin
                    chk("tx_data", tx_data, exp_q.pop_front());
                end
                if (last_start_cyc >= 0) begin
                    checks++;
                    if (cyc - last_start_cyc < 4) begin
                        errors++;
                        $display("FAIL start_spacing: got %0d expected >= 4", cyc - last_start_cyc);
                    end
                end
                if (fall_cyc > last_start_cyc && fall_cyc >= 0) begin
                    checks++;
                    if (cyc - fall_cyc < 2) begin
                        errors++;
                        $display("FAIL busy_to_start: got %0d expected >= 2", cyc - fall_cyc);
                    end
                end
                last_start_cyc = cyc;
                cur_word       = tx_data;
            end else if (tx_busy) begin
                chk("tx_data_hold", tx_data, cur_word);
            end
            prev_busy = tx_busy;
        end
    end

    // Stimulus tasks assume the caller sits at posedge+1.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge hash_clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [NM-1:0] f, input logic [NM*32-1:0] nv, input logic nw);
        found    = f;
        nonces   = nv;
        new_work = nw;
        idle(1);
        found    = '0;
        nonces   = '0;
        new_work = 1'b0;
    endtask

    task automatic strobe1(input int core, input logic [31:0] val);
        logic [NM-1:0]    f;
        logic [NM*32-1:0] nv;
        f  = '0;
        nv = '0;
        f[core]           = 1'b1;
        nv[core*32 +: 32] = val;
        strobe(f, nv, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_phase != 0 || tx_busy) && n < 3000) begin
            idle(1);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
        end
        idle(3);
    endtask

    int t0;
    int s0;

    initial begin
        reset = 1'b0;
        idle(3);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", tx_data, 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        reset = 1'b1;

        // Single result with 40-cycle busy.
        busy_len = 40;
        while (cyc < 10) idle(1);
        t0 = cyc;
        s0 = starts;
        exp_q.push_back(32'hDEADBEEF);
        strobe1(2, 32'hDEADBEEF);
        drain();
        chk("latency", 32'(last_start_cyc), 32'(t0 + 2));
        chk("single_starts", 32'(starts - s0), 32'd1);
        chk("single_drop", 32'(drop_count), 32'd0);

        // Fairness and wrap: rr_ptr is 3, core 3 granted, then cores 0 and 3.
        busy_len = 10;
        exp_q.push_back(32'h0000_3003);
        strobe1(3, 32'h0000_3003);
        idle(4);
        exp_q.push_back(32'h0000_00C0);
        exp_q.push_back(32'h0000_00C3);
        strobe(4'b1001, {32'h0000_00C3, 32'h0, 32'h0, 32'h0000_00C0}, 1'b0);
        drain();

        // Simultaneous strobes with rr_ptr back at 0.
        s0 = starts;
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h12);
        exp_q.push_back(32'h13);
        strobe(4'b1111, {32'h13, 32'h12, 32'h11, 32'h10}, 1'b0);
        drain();
        chk("simul_starts", 32'(starts - s0), 32'd4);
        chk("simul_drop", 32'(drop_count), 32'd0);

        // Overwrite while the transmitter is busy with core 0.
        busy_len = 40;
        exp_q.push_back(32'h100);
        strobe1(0, 32'h100);
        idle(4);
        exp_q.push_back(32'hB);
        strobe1(1, 32'hA);
        strobe1(1, 32'hB);
        chk("overwrite_drop", 32'(drop_count), 32'd1);
        drain();

        // Saturation: 300 overwrites of core 1 under one long busy.
        busy_len = 400;
        exp_q.push_back(32'h200);
        strobe1(0, 32'h200);
        idle(4);
        for (int k = 0; k < 300; k++) strobe1(1, 32'h1000 + 32'(k));
        exp_q.push_back(32'h1000 + 32'd299);
        chk("sat_drop", 32'(drop_count), 32'd255);
        drain();
        busy_len = 10;

        // Stale flush: cores 1,2 pending, new_work with found[3].
        busy_len = 20;
        exp_q.push_back(32'h300);
        strobe1(0, 32'h300);
        idle(4);
        strobe(4'b0110, {32'h0, 32'h22, 32'h21, 32'h0}, 1'b0);
`ifdef NONCE_TX_STALE_FLUSH_EN
        exp_q.push_back(32'h33);
`else
        exp_q.push_back(32'h21);
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h33);
`endif
        strobe(4'b1000, {32'h33, 32'h0, 32'h0, 32'h0}, 1'b1);
        drain();
        chk("flush_drop", 32'(drop_count), 32'd255);

        // Reset during WAIT_DONE with two slots pending.
        exp_q.push_back(32'h400);
        strobe1(0, 32'h400);
        idle(4);
        strobe(4'b0110, {32'h0, 32'h42, 32'h41, 32'h0}, 1'b0);
        idle(5);
        reset = 1'b0;
        #1;
        chk("midrst_tx_start", 32'(tx_start), 32'd0);
        chk("midrst_tx_data", tx_data, 32'd0);
        chk("midrst_drop", 32'(drop_count), 32'd0);
        exp_q.delete();
        idle(3);
        reset = 1'b1;
        s0 = starts;
        idle(20);
        chk("post_rst_no_start", 32'(starts - s0), 32'd0);
        exp_q.push_back(32'h55);
        strobe1(1, 32'h55);
        drain();
        chk("post_rst_starts", 32'(starts - s0), 32'd1);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
